o_writeback: RTL and testbench

Output write-back stage directly downstream of the PE. Accepts one normalized output vector per valid/ready handshake, converts each element from Q8.7 to Q0.7, and writes the row to O SRAM as consecutive WORD_W-bit beats. A two-entry ping-pong buffer lets the next vector be accepted while the current one drains. After ROWS vectors it pulses `done` and returns to idle.

---
 rtl/o_writeback_if.sv | 26 ++
 rtl/o_writeback.sv | 178 +++++++++++++++++
 tb/tb_o_writeback.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/o_writeback_if.sv
// Vector-in / SRAM-write-out bus of the output write-back stage.
// slave = the stage itself, master = its environment (PE side and O SRAM side).
interface o_writeback_if #(
  parameter int unsigned EMB_DIM = 64,
  parameter int unsigned IN_W    = 16,
  parameter int unsigned WORD_W  = 64,
  parameter int unsigned ADDR_W  = 12
);
  logic                      vld_in;
  logic                      rdy_out;
  logic [EMB_DIM*IN_W-1:0]   vec_in;
  logic                      sram_we;
  logic [ADDR_W-1:0]         sram_addr;
  logic [WORD_W-1:0]         sram_wdata;
  logic                      sram_rdy;

  modport master (
    output vld_in, vec_in, sram_rdy,
    input  rdy_out, sram_we, sram_addr, sram_wdata
  );

  modport slave (
    input  vld_in, vec_in, sram_rdy,
    output rdy_out, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/o_writeback.sv
// Output write-back: Q8.7 -> Q0.7 conversion, ping-pong row buffer, beat-wise O SRAM writes.
// Optional O_WB_SATURATE_EN selects saturating conversion instead of low-bit wrap.
module o_writeback #(
  parameter int unsigned EMB_DIM = 64,
  parameter int unsigned IN_W    = 16,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned WORD_W  = 64,
  parameter int unsigned ROWS    = 64,
  parameter int unsigned ADDR_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  o_writeback_if.slave      bus,
  output logic              busy,
  output logic              done
);

  localparam int unsigned ROW_BITS = EMB_DIM * OUT_W;
  localparam int unsigned BEATS    = ROW_BITS / WORD_W;
  localparam int unsigned BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned ROW_W    = $clog2(ROWS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [ROW_BITS-1:0]  buf_q [2];
  logic [ROW_BITS-1:0]  buf_d [2];
  logic [1:0]           full_q, full_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [ROW_W-1:0]     acc_q, acc_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 we_q, we_d;
  logic [WORD_W-1:0]    wdata_q, wdata_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [ROW_BITS-1:0]  conv_c;
  logic                 rdy_c;
  logic                 accept_c;
  logic                 fire_c;

`ifdef O_WB_SATURATE_EN
  localparam logic signed [IN_W-1:0] SAT_HI = IN_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] SAT_LO = IN_W'(-(2 ** (OUT_W - 1)));

  // Clamp each element into the Q0.7 range.
  always_comb begin
    logic signed [IN_W-1:0] elem;
    elem   = '0;
    conv_c = '0;
    for (int i = 0; i < int'(EMB_DIM); i++) begin
      elem = signed'(bus.vec_in[IN_W*i +: IN_W]);
      if (elem > SAT_HI)      conv_c[OUT_W*i +: OUT_W] = {1'b0, {(OUT_W-1){1'b1}}};
      else if (elem < SAT_LO) conv_c[OUT_W*i +: OUT_W] = {1'b1, {(OUT_W-1){1'b0}}};
      else                    conv_c[OUT_W*i +: OUT_W] = elem[OUT_W-1:0];
    end
  end
`else
  logic vec_unused_c;

  // Keep the low OUT_W bits of each element; upper bits are discarded by design.
  always_comb begin
    conv_c       = '0;
    vec_unused_c = 1'b0;
    for (int i = 0; i < int'(EMB_DIM); i++) begin
      conv_c[OUT_W*i +: OUT_W] = bus.vec_in[IN_W*i +: OUT_W];
      vec_unused_c = vec_unused_c ^ (^bus.vec_in[IN_W*i+OUT_W +: IN_W-OUT_W]);
    end
  end
`endif

  assign rdy_c    = (state_q == S_ACTIVE) && !full_q[wr_ptr_q] && (acc_q < ROW_W'(ROWS));
  assign accept_c = bus.vld_in && rdy_c;
  assign fire_c   = we_q && bus.sram_rdy;

  // Next state; the write port is reloaded from the post-update buffer view so a
  // freshly captured row can issue beat 0 on the very next cycle.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    full_d   = full_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    beat_d   = beat_q;
    row_d    = row_q;
    acc_d    = acc_q;
    addr_d   = addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ACTIVE;
          addr_d   = base_addr;
          beat_d   = '0;
          row_d    = '0;
          acc_d    = '0;
          full_d   = '0;
          wr_ptr_d = 1'b0;
          rd_ptr_d = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (accept_c) begin
          buf_d[wr_ptr_q]  = conv_c;
          full_d[wr_ptr_q] = 1'b1;
          wr_ptr_d         = ~wr_ptr_q;
          acc_d            = acc_q + ROW_W'(1);
        end
        if (fire_c) begin
          addr_d = addr_q + ADDR_W'(1);
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            beat_d           = '0;
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
            row_d            = row_q + ROW_W'(1);
            if (row_q == ROW_W'(ROWS - 1)) state_d = S_DONE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    we_d    = full_d[rd_ptr_d];
    wdata_d = buf_d[rd_ptr_d][WORD_W*beat_d +: WORD_W];
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      full_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      beat_q   <= '0;
      row_q    <= '0;
      acc_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q[0] <= buf_d[0];
      buf_q[1] <= buf_d[1];
      full_q   <= full_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      beat_q   <= beat_d;
      row_q    <= row_d;
      acc_q    <= acc_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.rdy_out    = rdy_c;
  assign bus.sram_we    = we_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_o_writeback.sv
// Randomized bench for o_writeback against a queue-based model of expected SRAM writes.
// Build with or without O_WB_SATURATE_EN; the model follows the same macro.
module tb_o_writeback;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned BEATS = 8;
  localparam int unsigned EMB   = 64;
  localparam int unsigned TOTAL = ROWS * BEATS;
`ifdef O_WB_SATURATE_EN
  localparam logic [15:0] SAT_EXP = 16'h807F;
`else
  localparam logic [15:0] SAT_EXP = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic        busy;
  logic        done;

  o_writeback_if bus_if ();

  o_writeback #(.ROWS(ROWS)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .bus       (bus_if),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [11:0] exp_addr_q [$];
  logic [63:0] exp_data_q [$];
  logic [15:0] el [EMB];
  bit          mon_en = 1'b0;
  int          rdy_pct = 100;
  int          cyc = 0;
  int          fires_tile = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  logic [63:0] first_data = '0;
  logic [11:0] first_addr = '0;
  bit          done_due = 1'b0;
  bit          busy_low_due = 1'b0;
  bit          stall_prev = 1'b0;
  logic [11:0] stall_addr = '0;
  logic [63:0] stall_data = '0;
  logic [11:0] tile_base = '0;
  int          model_row = 0;
  bit          rdy_now;
  bit          fire;
  logic [11:0] ea;
  logic [63:0] ed;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_conv(input logic [15:0] x);
`ifdef O_WB_SATURATE_EN
    int v;
    v = $signed(x);
    if (v > 127)  return 8'h7F;
    if (v < -128) return 8'h80;
`endif
    return x[7:0];
  endfunction

  // mode 0: random (biased toward the Q0.7 boundary), 1: element i = i, 2: saturation corners
  task automatic make_vec(input int mode);
    for (int i = 0; i < int'(EMB); i++) begin
      if (mode == 1)                     el[i] = 16'(i);
      else if ($urandom_range(0, 3) == 0) el[i] = 16'($urandom_range(0, 511)) - 16'd256;
      else                               el[i] = 16'($urandom);
    end
    if (mode == 2) begin
      el[0] = 16'h0100;
      el[1] = 16'hFF00;
    end
    for (int i = 0; i < int'(EMB); i++) bus_if.vec_in[16*i +: 16] = el[i];
  endtask

  task automatic push_row();
    logic [63:0] d;
    for (int b = 0; b < int'(BEATS); b++) begin
      d = '0;
      for (int j = 0; j < 8; j++) d[8*j +: 8] = ref_conv(el[b*8 + j]);
      exp_addr_q.push_back(12'(int'(tile_base) + model_row * int'(BEATS) + b));
      exp_data_q.push_back(d);
    end
    model_row++;
  endtask

  // Drives sram_rdy and checks every accepted write, stall stability and done/busy timing.
  initial begin
    bus_if.sram_rdy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        if (stall_prev) begin
          check("stall_we",    64'(bus_if.sram_we),    64'(1));
          check("stall_addr",  64'(bus_if.sram_addr),  64'(stall_addr));
          check("stall_wdata", bus_if.sram_wdata,      stall_data);
        end
        if (done_due) begin
          check("done_pulse",   64'(done), 64'(1));
          check("busy_at_done", 64'(busy), 64'(1));
          done_due     = 1'b0;
          busy_low_due = 1'b1;
        end else begin
          check("done_low", 64'(done), 64'(0));
          if (busy_low_due) begin
            check("busy_fall", 64'(busy), 64'(0));
            busy_low_due = 1'b0;
          end
        end
      end
      rdy_now         = ($urandom_range(0, 99) < rdy_pct);
      bus_if.sram_rdy = rdy_now;
      fire            = bus_if.sram_we && rdy_now;
      stall_prev      = mon_en && bus_if.sram_we && !rdy_now;
      stall_addr      = bus_if.sram_addr;
      stall_data      = bus_if.sram_wdata;
      if (mon_en && fire) begin
        if (exp_addr_q.size() == 0) begin
          check("spurious_write", 64'(bus_if.sram_addr), 64'hFFFF_FFFF);
        end else begin
          ea = exp_addr_q.pop_front();
          ed = exp_data_q.pop_front();
          check("wr_addr",  64'(bus_if.sram_addr), 64'(ea));
          check("wr_wdata", bus_if.sram_wdata,     ed);
        end
        if (fires_tile == 0) begin
          first_cyc  = cyc;
          first_data = bus_if.sram_wdata;
          first_addr = bus_if.sram_addr;
        end
        last_cyc = cyc;
        fires_tile++;
        if (fires_tile == int'(TOTAL)) done_due = 1'b1;
      end
    end
  end

  task automatic pulse_start(input logic [11:0] base);
    @(negedge clk);
    tile_base  = base;
    model_row  = 0;
    fires_tile = 0;
    start      = 1'b1;
    base_addr  = base;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive_rows(input int vld_pct, input int mode, input bit poke);
    int acc = 0;
    int guard = 0;
    bit poked = 1'b0;
    while (acc < int'(ROWS) && guard < 4000) begin
      @(negedge clk);
      guard++;
      start = 1'b0;
      if (poke && acc == 1 && !poked) begin
        start     = 1'b1;
        base_addr = ~tile_base;
        poked     = 1'b1;
      end
      make_vec(mode);
      bus_if.vld_in = ($urandom_range(0, 99) < vld_pct);
      if (bus_if.vld_in && bus_if.rdy_out) begin
        push_row();
        acc++;
      end
    end
    @(negedge clk);
    bus_if.vld_in = 1'b0;
    start         = 1'b0;
    check("rows_accepted", 64'(acc), 64'(ROWS));
  endtask

  task automatic wait_tile_end();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (fires_tile >= int'(TOTAL) && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("tile_finished", 64'(ok), 64'(1));
    repeat (2) @(negedge clk);
    check("tile_writes",   64'(fires_tile),        64'(TOTAL));
    check("model_drained", 64'(exp_addr_q.size()), 64'(0));
  endtask

  task automatic run_tile(input logic [11:0] base, input int vld_pct, input int rdy,
                          input int mode, input bit poke);
    rdy_pct = rdy;
    pulse_start(base);
    drive_rows(vld_pct, mode, poke);
    wait_tile_end();
  endtask

  // Holds the SRAM off so both entries fill, then lets the tile drain.
  task automatic stall_test();
    int acc = 0;
    rdy_pct = 0;
    pulse_start(12'h080);
    repeat (6) begin
      @(negedge clk);
      make_vec(0);
      bus_if.vld_in = 1'b1;
      if (bus_if.vld_in && bus_if.rdy_out) begin
        push_row();
        acc++;
      end
    end
    check("stall_accepts", 64'(acc),            64'(2));
    check("stall_rdy_low", 64'(bus_if.rdy_out), 64'(0));
    rdy_pct = 100;
    while (acc < int'(ROWS)) begin
      @(negedge clk);
      make_vec(0);
      if (bus_if.vld_in && bus_if.rdy_out) begin
        push_row();
        acc++;
      end
      if (cyc > 90000) break;
    end
    @(negedge clk);
    bus_if.vld_in = 1'b0;
    wait_tile_end();
  endtask

  // Aborts a tile during beat 3 of row 0 and checks outputs collapse at once.
  task automatic reset_test();
    bit seen = 1'b0;
    mon_en  = 1'b0;
    rdy_pct = 100;
    pulse_start(12'h200);
    make_vec(0);
    bus_if.vld_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus_if.vld_in = 1'b0;
      if (bus_if.sram_we && bus_if.sram_addr == 12'h203) begin
        seen = 1'b1;
        break;
      end
    end
    check("reset_beat3_seen", 64'(seen), 64'(1));
    rst_n = 1'b0;
    #1;
    check("arst_we",    64'(bus_if.sram_we),   64'(0));
    check("arst_addr",  64'(bus_if.sram_addr), 64'(0));
    check("arst_wdata", bus_if.sram_wdata,     64'(0));
    check("arst_rdy",   64'(bus_if.rdy_out),   64'(0));
    check("arst_busy",  64'(busy),             64'(0));
    check("arst_done",  64'(done),             64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_addr_q.delete();
    exp_data_q.delete();
    done_due     = 1'b0;
    busy_low_due = 1'b0;
    @(negedge clk);
    check("post_rst_we", 64'(bus_if.sram_we), 64'(0));
    mon_en = 1'b1;
  endtask

  initial begin
    bus_if.vld_in = 1'b0;
    bus_if.vec_in = '0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdy_out", 64'(bus_if.rdy_out),  64'(0));
    check("rst_we",      64'(bus_if.sram_we),  64'(0));
    check("rst_addr",    64'(bus_if.sram_addr), 64'(0));
    check("rst_wdata",   bus_if.sram_wdata,     64'(0));
    check("rst_busy",    64'(busy),             64'(0));
    check("rst_done",    64'(done),             64'(0));
    rst_n  = 1'b1;
    mon_en = 1'b1;

    run_tile(12'h100, 100, 100, 1, 1'b0);
    check("beat0_data",   first_data,                  64'h0706050403020100);
    check("first_addr",   64'(first_addr),             64'(12'h100));
    check("back_to_back", 64'(last_cyc - first_cyc),   64'(TOTAL - 1));

    stall_test();

    run_tile(12'h040, 100, 100, 2, 1'b0);
    check("sat_bytes", 64'(first_data[15:0]), 64'(SAT_EXP));

    run_tile(12'hFFC, 100, 100, 0, 1'b0);
    check("wrap_first_addr", 64'(first_addr), 64'(12'hFFC));

    run_tile(12'h300, 100, 100, 0, 1'b1);
    check("start_ignored_b2b", 64'(last_cyc - first_cyc), 64'(TOTAL - 1));

    for (int k = 0; k < 6; k++)
      run_tile(12'($urandom), int'($urandom_range(30, 100)), int'($urandom_range(20, 100)), 0, k[0]);

    reset_test();
    run_tile(12'h5A0, 70, 60, 0, 1'b0);
    check("restart_first_addr", 64'(first_addr), 64'(12'h5A0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
